timer_host_ctrl: RTL and testbench

TIMER_HOST_CTRL -- requirements
Module: timer_host_ctrl

---
 rtl/timer_host_pkg.sv | 42 ++++
 rtl/timer_host_tick_cnt.sv | 18 +
 rtl/timer_host_ctrl.sv | 149 ++++++++++++++
 tb/tb_timer_host_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_host_pkg.sv
// Shared definitions for the timer host controller: register map of the
// interval-timer slave, control register bit positions, the host FSM state
// encoding, and the control words written when starting/stopping the timer.
// Optional feature macro: TIMER_HOST_POLL_EN (adds the status-polling states).
package timer_host_pkg;

  // Timer slave register addresses (16-bit registers)
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Control words
  localparam logic [15:0] CTRL_RUN_IRQ  = (16'h1 << CTRL_START) | (16'h1 << CTRL_CONT)
                                        | (16'h1 << CTRL_ITO);
  localparam logic [15:0] CTRL_RUN_POLL = (16'h1 << CTRL_START) | (16'h1 << CTRL_CONT);
  localparam logic [15:0] CTRL_HALT     = (16'h1 << CTRL_STOP);

  typedef enum logic [3:0] {
    IDLE,
    WR_PERL,
    WR_PERH,
    WR_CTRL,
    WAIT_EVT,
    CLR_STAT,
    STOP_CTRL
`ifdef TIMER_HOST_POLL_EN
    ,
    POLL_RD,
    POLL_CHK
`endif
  } state_e;

endpackage

// File: rtl/timer_host_tick_cnt.sv
// 16-bit timeout counter for the timer host controller.
// Ports: clk, reset_n (async active-low clear), inc_en (count one event),
//        count (current value, wraps 0xFFFF -> 0x0000).
module timer_host_tick_cnt
  import timer_host_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc_en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (inc_en) count <= count + 16'd1;
  end

endmodule

// File: rtl/timer_host_ctrl.sv
// Avalon-MM host that programs and services an interval-timer slave.
// On cfg_start it writes PERIODL/PERIODH/CONTROL, then waits for a timeout
// (timer_irq, or status polling when TIMER_HOST_POLL_EN is defined), clears
// the status register and pulses tick. cfg_stop is remembered and serviced
// from WAIT_EVT by halting the timer and clearing status.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   cfg_period/start/stop      host configuration requests
//   avm_address/chipselect/write_n/writedata, avm_readdata   timer slave bus
//   timer_irq                  level interrupt from the slave
//   busy, tick, tick_count     status: sequencing, timeout pulse, event count
// Macro: TIMER_HOST_POLL_EN selects polling instead of interrupt mode.
module timer_host_ctrl
  import timer_host_pkg::*;
#(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  output logic [2:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [15:0]         avm_writedata,
  input  logic [15:0]         avm_readdata,
  input  logic                timer_irq,
  output logic                busy,
  output logic                tick,
  output logic [15:0]         tick_count
);

  state_e              state, nxt;
  logic [PERIOD_W-1:0] period_q;
  logic                stop_pend, stop_pend_nxt, stop_now;
  logic                from_stop;

`ifdef TIMER_HOST_POLL_EN
  logic unused_irq;
  logic unused_rd;
  assign unused_irq = timer_irq;
  assign unused_rd  = ^avm_readdata[15:1];
`else
  logic unused_rd;
  assign unused_rd  = ^avm_readdata;
`endif

  // A stop raised in the same cycle we sit in WAIT_EVT is acted on at once.
  assign stop_now = stop_pend | cfg_stop;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      period_q  <= '0;
      stop_pend <= 1'b0;
      from_stop <= 1'b0;
    end else begin
      state     <= nxt;
      stop_pend <= stop_pend_nxt;
      from_stop <= (state == STOP_CTRL);
      if (state == IDLE && cfg_start) period_q <= cfg_period;
    end
  end

  always_comb begin
    nxt            = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    tick           = 1'b0;
    case (state)
      IDLE: if (cfg_start) nxt = WR_PERL;
      WR_PERL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODL;
        avm_writedata  = period_q[15:0];
        nxt            = WR_PERH;
      end
      WR_PERH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODH;
        avm_writedata  = period_q[31:16];
        nxt            = WR_CTRL;
      end
      WR_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
`ifdef TIMER_HOST_POLL_EN
        avm_writedata  = CTRL_RUN_POLL;
`else
        avm_writedata  = CTRL_RUN_IRQ;
`endif
        nxt            = WAIT_EVT;
      end
      WAIT_EVT: begin
        if (stop_now)       nxt = STOP_CTRL;
`ifdef TIMER_HOST_POLL_EN
        else                nxt = POLL_RD;
`else
        else if (timer_irq) nxt = CLR_STAT;
`endif
      end
`ifdef TIMER_HOST_POLL_EN
      POLL_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_STATUS;
        nxt            = POLL_CHK;
      end
      // Read data for the POLL_RD address arrives in this cycle.
      POLL_CHK: nxt = avm_readdata[0] ? CLR_STAT : WAIT_EVT;
`endif
      CLR_STAT: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        tick           = ~from_stop;
        nxt            = from_stop ? IDLE : WAIT_EVT;
      end
      STOP_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_HALT;
        nxt            = CLR_STAT;
      end
      default: nxt = IDLE;
    endcase
  end

  // Pending stop: dropped in IDLE and once the stop sequence is entered.
  always_comb begin
    stop_pend_nxt = stop_pend | cfg_stop;
    if (state == IDLE || nxt == STOP_CTRL || nxt == IDLE) stop_pend_nxt = 1'b0;
  end

  timer_host_tick_cnt u_tick_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (tick),
    .count   (tick_count)
  );

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Scoreboard bench for timer_host_ctrl: stimulus pushes expected bus writes
// (address, data, tick, cycle) into a queue; a negedge monitor pops and
// compares every write the DUT presents. Cycle -1 means "any cycle".
module tb_timer_host_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cfg_period;
  logic        cfg_start, cfg_stop, timer_irq;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = '0;
  logic        busy, tick;
  logic [15:0] tick_count;

`ifdef TIMER_HOST_POLL_EN
  localparam logic [15:0] EXP_CTRL = 16'h0006;
`else
  localparam logic [15:0] EXP_CTRL = 16'h0007;
`endif

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        tick;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] rd_q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] model_cnt = '0;

  timer_host_ctrl #(.PERIOD_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_period     (cfg_period),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave read responder: data valid the cycle after the read address.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n && rd_q.size() > 0) avm_readdata <= rd_q.pop_front();
    else                                                  avm_readdata <= 16'h0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [15:0] d, input logic t, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.tick = t; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every write is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (avm_chipselect && !avm_write_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, want no access (cycle %0d)",
                 avm_address, avm_writedata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {29'd0, avm_address}, {29'd0, mon_e.addr});
        check("wr_data", {16'd0, avm_writedata}, {16'd0, mon_e.data});
        check("wr_tick", {31'd0, tick}, {31'd0, mon_e.tick});
        if (mon_e.cyc >= 0) check("wr_cycle", cyc, mon_e.cyc);
      end
    end else begin
      if (tick) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_tick: tick=1 without status write, want 0 (cycle %0d)", cyc);
      end
`ifndef TIMER_HOST_POLL_EN
      if (avm_chipselect) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_read: addr %0d, want no read (cycle %0d)", avm_address, cyc);
      end
`endif
    end
  end

  // Issue cfg_start at a negedge; returns at the next negedge (WR_PERL cycle).
  task automatic start(input logic [31:0] p, input bit full);
    cfg_period = p;
    cfg_start  = 1'b1;
    push_exp(3'd2, p[15:0], 1'b0, cyc + 1);
    if (full) begin
      push_exp(3'd3, p[31:16], 1'b0, cyc + 2);
      push_exp(3'd1, EXP_CTRL, 1'b0, cyc + 3);
    end
    @(negedge clk);
    cfg_start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // One timeout event, taken from WAIT_EVT.
  task automatic timer_event();
`ifdef TIMER_HOST_POLL_EN
    rd_q.push_back(16'h0000);
    rd_q.push_back(16'h0003);
    push_exp(3'd0, 16'h0000, 1'b1, -1);
    model_cnt++;
    repeat (8) @(negedge clk);
`else
    timer_irq = 1'b1;
    push_exp(3'd0, 16'h0000, 1'b1, cyc + 1);
    @(negedge clk);
    timer_irq = 1'b0;
    model_cnt++;
    repeat (2) @(negedge clk);
`endif
  endtask

  initial begin
    reset_n = 1'b0; cfg_period = '0; cfg_start = 1'b0; cfg_stop = 1'b0; timer_irq = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_chipselect", {31'd0, avm_chipselect}, 32'd0);
    check("rst_write_n",    {31'd0, avm_write_n},    32'd1);
    check("rst_address",    {29'd0, avm_address},    32'd0);
    check("rst_writedata",  {16'd0, avm_writedata},  32'd0);
    check("rst_busy",       {31'd0, busy},           32'd0);
    check("rst_tick",       {31'd0, tick},           32'd0);
    check("rst_tick_count", {16'd0, tick_count},     32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // cfg_stop in IDLE does nothing
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_stop_busy", {31'd0, busy}, 32'd0);

    // Program 0x0001C34F; a second cfg_start mid-sequence is ignored
    start(32'h0001C34F, 1'b1);
    cfg_period = 32'hDEADBEEF;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_wait_evt", {31'd0, busy}, 32'd1);

    timer_event();
    check("tick_count_1", {16'd0, tick_count}, {16'd0, model_cnt});
    timer_event();
    timer_event();
    check("tick_count_3", {16'd0, tick_count}, {16'd0, model_cnt});

`ifdef TIMER_HOST_POLL_EN
    // irq has no effect in polling mode
    timer_irq = 1'b1;
    repeat (6) @(negedge clk);
    timer_irq = 1'b0;
    check("poll_irq_ignored", {16'd0, tick_count}, {16'd0, model_cnt});
`endif

    // Counter state equal to 65535 prior events; one more wraps to zero
    force dut.u_tick_cnt.count = 16'hFFFF;
    release dut.u_tick_cnt.count;
    model_cnt = 16'hFFFF;
    timer_event();
    check("tick_count_wrap", {16'd0, tick_count}, 32'd0);

    // Stop and irq together: stop wins, no tick, back to IDLE
    cfg_stop  = 1'b1;
    timer_irq = 1'b1;
`ifdef TIMER_HOST_POLL_EN
    push_exp(3'd1, 16'h0008, 1'b0, -1);
    push_exp(3'd0, 16'h0000, 1'b0, -1);
    @(negedge clk);
    cfg_stop = 1'b0; timer_irq = 1'b0;
    repeat (8) @(negedge clk);
`else
    push_exp(3'd1, 16'h0008, 1'b0, cyc + 1);
    push_exp(3'd0, 16'h0000, 1'b0, cyc + 2);
    @(negedge clk);
    cfg_stop = 1'b0; timer_irq = 1'b0;
    repeat (2) @(negedge clk);
`endif
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_no_tick", {16'd0, tick_count}, {16'd0, model_cnt});

    // Period 0 is written as-is; stop during WR_PERL is deferred to WAIT_EVT
    start(32'h00000000, 1'b1);
    cfg_stop = 1'b1;
    push_exp(3'd1, 16'h0008, 1'b0, cyc + 4);
    push_exp(3'd0, 16'h0000, 1'b0, cyc + 5);
    @(negedge clk);
    cfg_stop = 1'b0;
    repeat (6) @(negedge clk);
    check("deferred_stop_busy", {31'd0, busy}, 32'd0);

    // Reset during WR_PERH: bus idles at once, no access after release
    start(32'h12345678, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_chipselect", {31'd0, avm_chipselect}, 32'd0);
    check("midrst_write_n",    {31'd0, avm_write_n},    32'd1);
    check("midrst_address",    {29'd0, avm_address},    32'd0);
    check("midrst_writedata",  {16'd0, avm_writedata},  32'd0);
    check("midrst_busy",       {31'd0, busy},           32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy",       {31'd0, busy},       32'd0);
    check("post_rst_tick_count", {16'd0, tick_count}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
